// File: rtl/in_fifo_tx.sv
// USB full-speed IN FIFO: app bytes -> SIE IN packets, released only on host ACK (IN_ZLP_EN adds ZLP after full packets).
// Latency: write visible next clk_i; in_req_i at gate N gives in_valid_o/in_nak_o from the next clk_i cycle.
// Backpressure: app_in_ready_o drops when storage (incl. sent-but-unACKed bytes) is full; SIE paces via in_ready_i.
module in_fifo_tx #(
    parameter int IN_MAXPACKETSIZE = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_gate_i,
    input  logic [7:0] app_in_data_i,
    input  logic       app_in_valid_i,
    output logic       app_in_ready_o,
    output logic       in_empty_o,
    output logic       in_full_o,
    input  logic       in_req_i,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    input  logic       in_data_ack_i,
    output logic       in_nak_o
);
    localparam int IN_LENGTH = IN_MAXPACKETSIZE + 1;
    localparam int PW = $clog2(IN_LENGTH);
    localparam int CW = $clog2(IN_MAXPACKETSIZE + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(IN_LENGTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(IN_MAXPACKETSIZE);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_ACK} state_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   first_q, first_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   last_q, last_d;
    logic [PW-1:0]   end_q, end_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            nak_q, nak_d;
    logic [7:0]      mem_q [IN_LENGTH];
    logic [7:0]      mem_d [IN_LENGTH];
`ifdef IN_ZLP_EN
    logic            zlp_q, zlp_d;
`endif

    logic            full;
    logic            empty;
    logic            wr_en;
    logic            in_valid;
    logic            new_req;
    logic            zlp_pend;
    logic [PW-1:0]   base_ptr;

    assign full           = (ptr_inc(last_q) == first_q);
    assign empty          = (first_q == last_q);
    assign wr_en          = app_in_valid_i & ~full;
    assign app_in_ready_o = ~full;
    assign in_empty_o     = empty;
    assign in_full_o      = full;
    assign in_nak_o       = nak_q;

    // end_q snapshot keeps bytes written mid-packet out of the current packet
    assign in_valid   = (state_q == ST_SEND) && (rd_q != end_q) && (cnt_q < CNT_MAX);
    assign in_valid_o = in_valid;
    assign in_data_o  = in_valid ? mem_q[rd_q] : 8'h00;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[last_q] = app_in_data_i;
        end
        last_d = wr_en ? ptr_inc(last_q) : last_q;
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        rd_d     = rd_q;
        end_d    = end_q;
        cnt_d    = cnt_q;
        nak_d    = nak_q;
        base_ptr = first_q;
        new_req  = 1'b0;
        zlp_pend = 1'b0;
`ifdef IN_ZLP_EN
        zlp_d    = zlp_q;
`endif
        if (clk_gate_i) begin
            case (state_q)
                ST_IDLE: begin
                    new_req = in_req_i;
                end
                ST_SEND: begin
                    if (in_ready_i) begin
                        if (in_valid) begin
                            rd_d  = ptr_inc(rd_q);
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            state_d = ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (in_data_ack_i) begin
                        // commit first so a simultaneous token sees the freed space
                        first_d  = rd_q;
                        base_ptr = rd_q;
                        state_d  = ST_IDLE;
                        new_req  = in_req_i;
`ifdef IN_ZLP_EN
                        zlp_d    = (cnt_q == CNT_MAX);
`endif
                    end else if (in_req_i) begin
                        rd_d    = first_q;
                        end_d   = last_q;
                        cnt_d   = '0;
                        state_d = ST_SEND;
`ifdef IN_ZLP_EN
                        if (!empty) begin
                            zlp_d = 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

`ifdef IN_ZLP_EN
            zlp_pend = zlp_d;
`endif
            if (new_req) begin
                if ((base_ptr != last_q) || zlp_pend) begin
                    nak_d   = 1'b0;
                    rd_d    = base_ptr;
                    end_d   = last_q;
                    cnt_d   = '0;
                    state_d = ST_SEND;
`ifdef IN_ZLP_EN
                    if (base_ptr != last_q) begin
                        zlp_d = 1'b0;
                    end
`endif
                end else begin
                    nak_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            first_q <= '0;
            rd_q    <= '0;
            last_q  <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            nak_q   <= 1'b0;
            for (int i = 0; i < IN_LENGTH; i++) begin
                mem_q[i] <= 8'h00;
            end
`ifdef IN_ZLP_EN
            zlp_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            rd_q    <= rd_d;
            last_q  <= last_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            nak_q   <= nak_d;
            for (int i = 0; i < IN_LENGTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef IN_ZLP_EN
            zlp_q   <= zlp_d;
`endif
        end
    end
endmodule

// File: tb/tb_in_fifo_tx.sv
// Scoreboard bench for in_fifo_tx: a byte-queue model predicts each packet, ACK release and flags.
module tb_in_fifo_tx;
    localparam int MPS = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       clk_gate_i;
    logic [7:0] app_in_data_i;
    logic       app_in_valid_i;
    logic       app_in_ready_o;
    logic       in_empty_o;
    logic       in_full_o;
    logic       in_req_i;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;
    logic       in_data_ack_i;
    logic       in_nak_o;

    in_fifo_tx #(.IN_MAXPACKETSIZE(MPS)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clk_gate_i     (clk_gate_i),
        .app_in_data_i  (app_in_data_i),
        .app_in_valid_i (app_in_valid_i),
        .app_in_ready_o (app_in_ready_o),
        .in_empty_o     (in_empty_o),
        .in_full_o      (in_full_o),
        .in_req_i       (in_req_i),
        .in_data_o      (in_data_o),
        .in_valid_o     (in_valid_o),
        .in_ready_i     (in_ready_i),
        .in_data_ack_i  (in_data_ack_i),
        .in_nak_o       (in_nak_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // one gated SIE period: gate high for one clk_i, then three idle clocks
    task automatic sie_cycle(input logic req, input logic rdy, input logic ack);
        clk_gate_i = 1'b1; in_req_i = req; in_ready_i = rdy; in_data_ack_i = ack;
        @(posedge clk_i); #1;
        clk_gate_i = 1'b0; in_req_i = 1'b0; in_ready_i = 1'b0; in_data_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        chk("app_rdy_before_wr", app_in_ready_o, model.size() < MPS);
        app_in_valid_i = 1'b1; app_in_data_i = b;
        @(posedge clk_i); #1;
        app_in_valid_i = 1'b0;
        if (model.size() < MPS) model.push_back(b);
        chk("empty_after_wr", in_empty_o, model.size() == 0);
        chk("full_after_wr", in_full_o, model.size() == MPS);
    endtask

    task automatic send_packet(input bit do_ack);
        int n;
        int guard;
        n = (model.size() > MPS) ? MPS : model.size();
        for (int i = 0; i < n; i++) exp_q.push_back(model[i]);
        sie_cycle(1'b1, 1'b0, 1'b0);
        chk("nak_on_req", in_nak_o, 1'b0);
        chk("valid_on_req", in_valid_o, n > 0);
        guard = 0;
        while (in_valid_o && guard < 20) begin
            if (exp_q.size() == 0) begin
                chk("pkt_extra_byte", in_valid_o, 1'b0);
                break;
            end
            chk("pkt_byte", in_data_o, exp_q.pop_front());
            sie_cycle(1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("pkt_bytes_left", exp_q.size(), 0);
        exp_q.delete();
        sie_cycle(1'b0, 1'b1, 1'b0);
        chk("valid_after_close", in_valid_o, 1'b0);
        if (do_ack) begin
            sie_cycle(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < n; i++) void'(model.pop_front());
            chk("empty_after_ack", in_empty_o, model.size() == 0);
            chk("rdy_after_ack", app_in_ready_o, model.size() < MPS);
        end
    endtask

    initial begin
        rst_i = 1'b1; clk_gate_i = 1'b0; app_in_data_i = 8'h00; app_in_valid_i = 1'b0;
        in_req_i = 1'b0; in_ready_i = 1'b0; in_data_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        chk("rst_valid", in_valid_o, 1'b0);
        chk("rst_data", in_data_o, 8'h00);
        chk("rst_nak", in_nak_o, 1'b0);
        chk("rst_app_rdy", app_in_ready_o, 1'b1);
        chk("rst_empty", in_empty_o, 1'b1);
        chk("rst_full", in_full_o, 1'b0);

        // basic three-byte packet
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        send_packet(1'b1);

        // NAK on empty, then data clears it
        sie_cycle(1'b1, 1'b0, 1'b0);
        chk("nak_empty", in_nak_o, 1'b1);
        chk("valid_empty", in_valid_o, 1'b0);
        write_byte(8'h55);
        chk("nak_held_until_req", in_nak_o, 1'b1);
        send_packet(1'b1);

        // retry without ACK resends the same bytes
        write_byte(8'hA0); write_byte(8'hA1);
        send_packet(1'b0);
        chk("retry_not_empty", in_empty_o, 1'b0);
        send_packet(1'b1);

        // fill storage, ninth write refused, full packet released on ACK
        for (int i = 0; i < MPS; i++) write_byte(8'hC0 + 8'(i));
        chk("full_set", in_full_o, 1'b1);
        chk("app_rdy_full", app_in_ready_o, 1'b0);
        write_byte(8'hEE);
        send_packet(1'b1);
        chk("full_clear", in_full_o, 1'b0);

        // token on empty after a max-size packet
        sie_cycle(1'b1, 1'b0, 1'b0);
        chk("zlp_valid", in_valid_o, 1'b0);
`ifdef IN_ZLP_EN
        chk("zlp_nak", in_nak_o, 1'b0);
        sie_cycle(1'b0, 1'b1, 1'b0);
        sie_cycle(1'b0, 1'b0, 1'b1);
        sie_cycle(1'b1, 1'b0, 1'b0);
        chk("zlp_done_nak", in_nak_o, 1'b1);
`else
        chk("no_zlp_nak", in_nak_o, 1'b1);
`endif

        // pointer wrap: three 5-byte packets
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) write_byte(8'(p * 5 + i));
            send_packet(1'b1);
        end

        // reset mid-packet discards everything
        write_byte(8'h77); write_byte(8'h78);
        sie_cycle(1'b1, 1'b0, 1'b0);
        chk("midpkt_valid", in_valid_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model.delete();
        chk("rst2_empty", in_empty_o, 1'b1);
        chk("rst2_valid", in_valid_o, 1'b0);
        chk("rst2_full", in_full_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
